// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer between a show-ahead TX FIFO, an RX FIFO and the SPI pins.
// Define SPI_MASTER_CTRL_BURST_EN to chain words back-to-back with cs_n held low.
module spi_master_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  tx_empty,
  input  logic [DATA_WIDTH-1:0] tx_dout,
  output logic                  tx_rd_en,
  input  logic                  rx_full,
  output logic [DATA_WIDTH-1:0] rx_din,
  output logic                  rx_wr_en,
  input  logic                  ovf_clr,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  rx_overflow
);

  localparam int unsigned HCW = $clog2(CLK_DIV) + 1;
  localparam int unsigned BCW = $clog2(DATA_WIDTH) + 1;
  localparam logic [HCW-1:0] HalfLast = HCW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] BitLast  = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StLead, StShift, StStore, StGap} state_e;

  state_e                  state_q, state_d;
  logic [HCW-1:0]          hcnt_q, hcnt_d;
  logic [BCW-1:0]          bcnt_q, bcnt_d;
  logic                    sclk_q, sclk_d;
  logic [DATA_WIDTH-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0]   rx_sr_q, rx_sr_d;
  logic                    ovf_q, ovf_d;
  logic                    pop, push;
  logic                    cs_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      sclk_q  <= 1'b0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      sclk_q  <= sclk_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    sclk_d  = sclk_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    ovf_d   = ovf_clr ? 1'b0 : ovf_q;
    pop     = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        sclk_d = 1'b0;
        if (enable && !tx_empty) begin
          pop     = 1'b1;
          tx_sr_d = tx_dout;
          hcnt_d  = HalfLast;
          bcnt_d  = '0;
          state_d = StLead;
        end
      end
      StLead: begin
        if (hcnt_q == '0) begin
          hcnt_d  = HalfLast;
          bcnt_d  = '0;
          state_d = StShift;
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end
      StShift: begin
        if (hcnt_q != '0) begin
          hcnt_d = hcnt_q - 1'b1;
        end else begin
          hcnt_d = HalfLast;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], miso};
          end else begin
            sclk_d = 1'b0;
            if (bcnt_q == BitLast) begin
              bcnt_d  = '0;
              state_d = StStore;
            end else begin
              // Falling edge: present the next bit a full half-period before it is sampled.
              tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
              bcnt_d  = bcnt_q + BCW'(1);
            end
          end
        end
      end
      StStore: begin
        if (rx_full) begin
          ovf_d = 1'b1;
        end else begin
          push = 1'b1;
        end
        hcnt_d = HalfLast;
        bcnt_d = '0;
`ifdef SPI_MASTER_CTRL_BURST_EN
        if (enable && !tx_empty) begin
          pop     = 1'b1;
          tx_sr_d = tx_dout;
          state_d = StShift;
        end else begin
          state_d = StGap;
        end
`else
        state_d = StGap;
`endif
      end
      StGap: begin
        if (hcnt_q == '0) begin
          hcnt_d  = HalfLast;
          bcnt_d  = '0;
          state_d = StIdle;
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cs_active = (state_q == StLead) || (state_q == StShift) || (state_q == StStore);

  // Strobes are gated by reset so nothing pops or pushes while rst_n is held low.
  assign tx_rd_en    = pop & rst_n;
  assign rx_wr_en    = push & rst_n;
  assign rx_din      = (state_q == StStore) ? rx_sr_q : '0;
  assign cs_n        = ~cs_active;
  assign sclk        = sclk_q;
  assign mosi        = cs_active & tx_sr_q[DATA_WIDTH-1];
  assign busy        = (state_q != StIdle);
  assign rx_overflow = ovf_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl (DATA_WIDTH=8, CLK_DIV=2), miso looped back to mosi.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       tx_empty;
  logic [7:0] tx_dout;
  logic       tx_rd_en;
  logic       rx_full;
  logic [7:0] rx_din;
  logic       rx_wr_en;
  logic       ovf_clr;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;
  logic       busy;
  logic       rx_overflow;

  spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .tx_empty    (tx_empty),
    .tx_dout     (tx_dout),
    .tx_rd_en    (tx_rd_en),
    .rx_full     (rx_full),
    .rx_din      (rx_din),
    .rx_wr_en    (rx_wr_en),
    .ovf_clr     (ovf_clr),
    .sclk        (sclk),
    .mosi        (mosi),
    .miso        (miso),
    .cs_n        (cs_n),
    .busy        (busy),
    .rx_overflow (rx_overflow)
  );

  always #5 clk = ~clk;
  assign miso = mosi;

  // Show-ahead TX FIFO model.
  logic [7:0] tx_mem [16];
  logic [3:0] wr_ptr = '0;
  logic [3:0] rd_ptr = '0;
  assign tx_empty = (wr_ptr == rd_ptr);
  assign tx_dout  = tx_mem[rd_ptr];
  always @(posedge clk) if (tx_rd_en) rd_ptr <= rd_ptr + 4'd1;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int sclk_rises = 0;
  logic [7:0] mosi_bits = '0;
  logic prev_sclk = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  // Called at a negedge; returns at negedge+2 of the cycle where tx_rd_en is high.
  task automatic wait_pop(input string name);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (tx_rd_en) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check(name, int'(ok), 1);
  endtask

  // Counts busy cycles following the pop cycle; optionally drops enable at a given count.
  task automatic count_busy(input int drop_at, output int cnt);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cnt == drop_at) enable = 1'b0;
      #2;
      if (busy) cnt++;
      else break;
    end
  endtask

  int rd0, wr0, r0, cnt, high_run, busy_seen;
  bit saw_low;
  int gaps[$];

  initial begin
    rst_n = 1'b0; enable = 1'b1; rx_full = 1'b0; ovf_clr = 1'b0;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          #1;
          if (tx_rd_en) rd_pulses++;
          if (rx_wr_en) begin
            wr_pulses++;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_err++;
              $display("FAIL rx_unexpected: got push of 0x%0h required no push", rx_din);
            end else begin
              check("rx_din", int'(rx_din), int'(exp_q.pop_front()));
            end
          end
          if (sclk && !prev_sclk) begin
            mosi_bits = {mosi_bits[6:0], mosi};
            sclk_rises++;
          end
          prev_sclk = sclk;
        end
      end
      begin : stimulus
        // 1. Reset values, then idle with an empty TX FIFO.
        repeat (3) @(negedge clk);
        #2;
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_sclk", int'(sclk), 0);
        check("rst_mosi", int'(mosi), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(rx_overflow), 0);
        check("rst_strobes", int'({tx_rd_en, rx_wr_en}), 0);
        check("rst_rx_din", int'(rx_din), 0);
        @(negedge clk);
        rst_n = 1'b1;
        busy_seen = 0;
        repeat (20) begin
          @(negedge clk); #2;
          if (busy) busy_seen++;
        end
        check("idle_busy", busy_seen, 0);

        // 2. Single word 0xA5.
        @(negedge clk);
        rd0 = rd_pulses; wr0 = wr_pulses; r0 = sclk_rises;
        exp_q.push_back(8'hA5);
        push_tx(8'hA5);
        wait_pop("single_pop");
        count_busy(-1, cnt);
        check("single_busy_cycles", cnt, 37);
        check("single_pops", rd_pulses - rd0, 1);
        check("single_pushes", wr_pulses - wr0, 1);
        check("single_sclk_rises", sclk_rises - r0, 8);
        check("single_mosi_bits", int'(mosi_bits), 'hA5);

        // 3. Three words; record cs_n high stretches between words.
        @(negedge clk);
        wr0 = wr_pulses;
        foreach (exp_q[i]) ;
        exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'hFF);
        push_tx(8'h01); push_tx(8'h80); push_tx(8'hFF);
        saw_low = 0; high_run = 0; gaps.delete();
        for (int i = 0; i < 500; i++) begin
          #2;
          if (wr_pulses - wr0 >= 3) break;
          if (!cs_n) begin
            if (saw_low && high_run > 0) gaps.push_back(high_run);
            saw_low = 1; high_run = 0;
          end else if (saw_low) begin
            high_run++;
          end
          @(negedge clk);
        end
        check("three_pushes", wr_pulses - wr0, 3);
`ifdef SPI_MASTER_CTRL_BURST_EN
        check("three_cs_gaps", gaps.size(), 0);
`else
        check("three_cs_gaps", gaps.size(), 2);
        foreach (gaps[i]) check("three_cs_high_len", gaps[i], 3);
`endif
        count_busy(-1, cnt);

        // 4. RX overflow, then set and clear in the same cycle.
        for (int w = 0; w < 2; w++) begin
          @(negedge clk);
          rx_full = 1'b1;
          wr0 = wr_pulses;
          push_tx(w == 0 ? 8'h3C : 8'hC3);
          wait_pop("ovf_pop");
          repeat (35) @(negedge clk);
          #2;
          check("ovf_store_cs_n", int'(cs_n), 0);
          check("ovf_store_no_wr", int'(rx_wr_en), 0);
          check("ovf_before_set", int'(rx_overflow), 0);
          if (w == 1) ovf_clr = 1'b1;
          @(negedge clk);
          ovf_clr = 1'b0;
          #2;
          check("ovf_after_store", int'(rx_overflow), 1);
          count_busy(-1, cnt);
          repeat (5) @(negedge clk);
          #2;
          check("ovf_sticky", int'(rx_overflow), 1);
          check("ovf_no_pushes", wr_pulses - wr0, 0);
          @(negedge clk); ovf_clr = 1'b1;
          @(negedge clk); ovf_clr = 1'b0;
          #2;
          check("ovf_cleared", int'(rx_overflow), 0);
        end
        rx_full = 1'b0;

        // 5. Reset during the 4th SCLK period (high phase).
        @(negedge clk);
        push_tx(8'h11); push_tx(8'h22);
        wait_pop("rst_mid_pop");
        repeat (17) @(negedge clk);
        #2;
        check("rst_mid_sclk_high", int'(sclk), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cs_n", int'(cs_n), 1);
        check("rst_mid_sclk", int'(sclk), 0);
        rd0 = rd_pulses; wr0 = wr_pulses;
        repeat (5) @(negedge clk);
        #2;
        check("rst_mid_no_pop", rd_pulses - rd0, 0);
        check("rst_mid_no_push", wr_pulses - wr0, 0);
        check("rst_mid_tx_kept", int'(tx_empty), 0);
        @(negedge clk);
        exp_q.push_back(8'h22);
        rst_n = 1'b1;
        wait_pop("rst_release_pop");
        count_busy(-1, cnt);
        check("rst_release_busy", cnt, 37);

        // 6. Enable drop mid-word with two words queued.
        @(negedge clk);
        rd0 = rd_pulses; wr0 = wr_pulses;
        exp_q.push_back(8'h5A);
        push_tx(8'h5A); push_tx(8'hC3);
        wait_pop("en_drop_pop");
        count_busy(10, cnt);
        check("en_drop_busy", cnt, 37);
        busy_seen = 0;
        repeat (20) begin
          @(negedge clk); #2;
          if (busy) busy_seen++;
        end
        check("en_drop_idle", busy_seen, 0);
        check("en_drop_pops", rd_pulses - rd0, 1);
        check("en_drop_pushes", wr_pulses - wr0, 1);
        check("en_drop_tx_left", int'(tx_empty), 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
      end
    join_any
  end

endmodule
